genesis_pad_scanner: RTL and testbench
======================================

# genesis_pad_scanner

Scans up to NUM_PADS SEGA Genesis pads (3- or 6-button) by driving the shared select line itself through the full 8-phase 6-button protocol. It decodes all 12 buttons, detects pad presence and 6-button capability, and debounces per frame. Once per frame it presents stable, active-high button state plus one-cycle new-press pulses to the robot top-level control logic.

## Interface
Parameters:
- NUM_PADS, 2: number of pads sharing the select line (1..4).
- SEL_CYCLES, 500: clocks per select phase (≥4).
- IDLE_CYCLES, 100000: clocks between frames, select held high; must exceed the pad's 1.5 ms counter timeout.
- DEBOUNCE_FRAMES, 2: consecutive identical raw frames required to commit a change (≥1).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  start new frames while high.
- pad_pins  in  6*NUM_PADS  raw DB-9 pins, active-low; per pad p, bits [6p+5:6p] = {start_c, a_b, right, left, down, up_z}.
- select  out  1  select signal to all pads.
- buttons  out  12*NUM_PADS  debounced state, 1 = pressed; per pad bits [0..11] = up, down, left, right, A, B, C, start, X, Y, Z, mode.
- new_press  out  12*NUM_PADS  one-cycle pulse, coincident with frame_valid, for each button committed 0→1.
- present  out  NUM_PADS  pad detected in last frame.
- six_button  out  NUM_PADS  pad answered 6-button ID in last frame.
- frame_valid  out  1  one-cycle pulse when outputs update.

## Operation
- Every pad_pins bit passes through a 2-flop synchronizer. Sampling occurs on the last cycle of each phase, which gives ≥2 cycles of settling.
- FSM states and select levels: IDLE(1), PH0(1), PH1(0), PH2(1), PH3(0), PH4(1), PH5(0), PH6(1), PH7(0). Each PHn lasts SEL_CYCLES clocks; IDLE lasts at least IDLE_CYCLES.
- IDLE→PH0 only when the idle counter has expired and enable=1. Otherwise the FSM stays in IDLE with the counter saturated. PHn→PHn+1 unconditionally; PH7→IDLE with the counter cleared.
- enable=0 mid-frame: the current frame completes and is reported.
- Per-pad sample decode (pins inverted, so 1 = low):
  - PH0: up, down, left, right, B←a_b, C←start_c.
  - PH1: A←a_b, start←start_c. present_raw = left & right (both pins low).
  - PH5: six_raw = up & down & left & right (all low).
  - PH6: valid only if six_raw. Z←up_z, Y←down, X←left, mode←right.
  - If six_raw=0, X/Y/Z/mode raw = 0. If present_raw=0, all 12 raw = 0 and six_raw = 0.
- Debounce, per pad, at end of PH7:
  - If raw == candidate, count++ (saturating).
  - Otherwise candidate←raw and count←1.
  - When count ≥ DEBOUNCE_FRAMES, buttons←candidate.
  - new_press = candidate & ~old buttons.
  - present and six_button are updated from raw every frame, without debounce.

## Timing
- Reset values: select=1, buttons=0, new_press=0, present=0, six_button=0, frame_valid=0, FSM=IDLE, idle counter=0.
- The first frame starts IDLE_CYCLES clocks after reset release, provided enable=1.
- Frame period = IDLE_CYCLES + 8*SEL_CYCLES clocks.
- frame_valid, new_press and the updated outputs are registered. They are visible in the first IDLE cycle after PH7. new_press is 0 in all other cycles.
- Latency from a stable pin change to a buttons change: between DEBOUNCE_FRAMES and DEBOUNCE_FRAMES+1 frames.
- Reset asserted mid-frame discards the partial frame; select returns to 1 asynchronously.
- Pin glitches shorter than 2 cycles that do not straddle a sample point are ignored.

## Structure
- Package genesis_pkg holds:
  - BTN_W=12, PIN_W=6.
  - Button index constants (BTN_UP … BTN_MODE).
  - Pin index constants.
  - Phase enum (ST_IDLE, ST_PH0..ST_PH7).
- Sub-module pad_decode_debounce, instantiated NUM_PADS times. It owns the per-pad sample registers, decode, candidate/count, buttons, new_press, present and six_button. It is driven by phase-strobe inputs from the top FSM.
- The top level owns the synchronizers, phase/idle counters, FSM, select and frame_valid.

## Test plan
Configuration for all scenarios: NUM_PADS=2, SEL_CYCLES=4, IDLE_CYCLES=16, DEBOUNCE_FRAMES=2.
- Reset release with all pins high, enable=1 → select toggles with period 8 after 16 idle clocks. frame_valid pulses every 48 clocks. present=00; buttons=0.
- Pad 0 modelled as a 3-button pad holding A (pins driven per select level) → present[0]=1, six_button[0]=0. After 2 frames buttons[4]=1; new_press[4] pulses once only.
- Pad 1 modelled as a 6-button pad holding Z and mode → six_button[1]=1 on the first frame. After 2 frames buttons bits 10 and 11 of pad 1 are 1; X/Y stay 0.
- Pad 0 B line toggled on alternating frames → buttons[5] never changes, new_press stays 0.
- reset pulled low during PH3 → select=1 in the same cycle and all outputs 0. After release, the first frame_valid occurs 48 clocks later.
- enable dropped during PH2 → the frame completes with one frame_valid; select stays 1 afterward with no further frames until enable returns.

Source files
------------

// File: rtl/genesis_pad_scanner_pkg.sv
// Shared constants and types for the Genesis pad scanner: pin/button index
// maps, the scan phase enum and two small phase helpers.
package genesis_pkg;

  localparam int BTN_W = 12;
  localparam int PIN_W = 6;

  // Button bit positions in the decoded, active-high button word.
  localparam int BTN_UP    = 0;
  localparam int BTN_DOWN  = 1;
  localparam int BTN_LEFT  = 2;
  localparam int BTN_RIGHT = 3;
  localparam int BTN_A     = 4;
  localparam int BTN_B     = 5;
  localparam int BTN_C     = 6;
  localparam int BTN_START = 7;
  localparam int BTN_X     = 8;
  localparam int BTN_Y     = 9;
  localparam int BTN_Z     = 10;
  localparam int BTN_MODE  = 11;

  // Pin bit positions inside one pad's 6-bit DB-9 group (active-low pins).
  localparam int PIN_UP_Z    = 0;
  localparam int PIN_DOWN    = 1;
  localparam int PIN_LEFT    = 2;
  localparam int PIN_RIGHT   = 3;
  localparam int PIN_A_B     = 4;
  localparam int PIN_START_C = 5;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_PH0,
    ST_PH1,
    ST_PH2,
    ST_PH3,
    ST_PH4,
    ST_PH5,
    ST_PH6,
    ST_PH7
  } phase_e;

  // Select level driven while in a given state: high in IDLE and even phases.
  function automatic logic phase_select(input phase_e st);
    case (st)
      ST_PH1, ST_PH3, ST_PH5, ST_PH7: phase_select = 1'b0;
      default:                        phase_select = 1'b1;
    endcase
  endfunction

  // Phase that follows st inside a frame; PH7 wraps back to IDLE.
  function automatic phase_e next_phase(input phase_e st);
    case (st)
      ST_IDLE: next_phase = ST_PH0;
      ST_PH0:  next_phase = ST_PH1;
      ST_PH1:  next_phase = ST_PH2;
      ST_PH2:  next_phase = ST_PH3;
      ST_PH3:  next_phase = ST_PH4;
      ST_PH4:  next_phase = ST_PH5;
      ST_PH5:  next_phase = ST_PH6;
      ST_PH6:  next_phase = ST_PH7;
      default: next_phase = ST_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/genesis_pad_scanner_pad_decode_debounce.sv
// One pad's worth of decode and debounce. The top FSM pulses a strobe on the
// last cycle of each phase that carries useful pin data; this block latches
// the relevant pins into an active-high button word, then folds the frame
// into the debouncer when commit_i fires at the end of PH7.
module pad_decode_debounce
  import genesis_pkg::*;
#(
  parameter int DEBOUNCE_FRAMES = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [PIN_W-1:0] pins_i,
  input  logic             smp_ph0_i,
  input  logic             smp_ph1_i,
  input  logic             smp_ph5_i,
  input  logic             smp_ph6_i,
  input  logic             commit_i,
  output logic [BTN_W-1:0] buttons_o,
  output logic [BTN_W-1:0] new_press_o,
  output logic             present_o,
  output logic             six_button_o
);

  localparam int CNT_W = $clog2(DEBOUNCE_FRAMES + 1);
  localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(DEBOUNCE_FRAMES);

  logic [PIN_W-1:0] act_low;
  logic [BTN_W-1:0] smp_q;
  logic             pres_smp_q;
  logic             six_smp_q;
  logic [BTN_W-1:0] raw_btn;
  logic             raw_six;
  logic [BTN_W-1:0] cand_q, cand_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [BTN_W-1:0] buttons_q, buttons_d;
  logic [BTN_W-1:0] new_press_q;
  logic             present_q;
  logic             six_button_q;

  // Pins are active-low; a 1 here means the line is pulled low.
  assign act_low = ~pins_i;

  // Capture the pins that matter in each phase into the raw button word.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      smp_q      <= '0;
      pres_smp_q <= 1'b0;
      six_smp_q  <= 1'b0;
    end else begin
      if (smp_ph0_i) begin
        smp_q[BTN_UP]    <= act_low[PIN_UP_Z];
        smp_q[BTN_DOWN]  <= act_low[PIN_DOWN];
        smp_q[BTN_LEFT]  <= act_low[PIN_LEFT];
        smp_q[BTN_RIGHT] <= act_low[PIN_RIGHT];
        smp_q[BTN_B]     <= act_low[PIN_A_B];
        smp_q[BTN_C]     <= act_low[PIN_START_C];
      end
      if (smp_ph1_i) begin
        smp_q[BTN_A]     <= act_low[PIN_A_B];
        smp_q[BTN_START] <= act_low[PIN_START_C];
        // A connected pad grounds left and right while select is low.
        pres_smp_q       <= act_low[PIN_LEFT] & act_low[PIN_RIGHT];
      end
      if (smp_ph5_i) begin
        // A 6-button pad grounds all four direction lines in the third low phase.
        six_smp_q <= act_low[PIN_UP_Z] & act_low[PIN_DOWN] &
                     act_low[PIN_LEFT] & act_low[PIN_RIGHT];
      end
      if (smp_ph6_i) begin
        smp_q[BTN_Z]    <= act_low[PIN_UP_Z];
        smp_q[BTN_Y]    <= act_low[PIN_DOWN];
        smp_q[BTN_X]    <= act_low[PIN_LEFT];
        smp_q[BTN_MODE] <= act_low[PIN_RIGHT];
      end
    end
  end

  // Mask out extended buttons on 3-button pads and everything on absent pads.
  always_comb begin
    raw_btn = smp_q;
    if (!six_smp_q) begin
      raw_btn[BTN_X]    = 1'b0;
      raw_btn[BTN_Y]    = 1'b0;
      raw_btn[BTN_Z]    = 1'b0;
      raw_btn[BTN_MODE] = 1'b0;
    end
    if (!pres_smp_q) begin
      raw_btn = '0;
    end
    raw_six = pres_smp_q & six_smp_q;
  end

  // Debounce next-state: count identical frames, commit once the run is long enough.
  always_comb begin
    cand_d    = cand_q;
    cnt_d     = cnt_q;
    buttons_d = buttons_q;
    if (raw_btn == cand_q) begin
      if (cnt_q < CNT_SAT) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      cand_d = raw_btn;
      cnt_d  = CNT_W'(1);
    end
    if (cnt_d >= CNT_SAT) begin
      buttons_d = cand_d;
    end
  end

  // Frame-end update of the debouncer and the registered outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cand_q       <= '0;
      cnt_q        <= '0;
      buttons_q    <= '0;
      new_press_q  <= '0;
      present_q    <= 1'b0;
      six_button_q <= 1'b0;
    end else begin
      new_press_q <= '0;
      if (commit_i) begin
        cand_q       <= cand_d;
        cnt_q        <= cnt_d;
        buttons_q    <= buttons_d;
        new_press_q  <= buttons_d & ~buttons_q;
        present_q    <= pres_smp_q;
        six_button_q <= raw_six;
      end
    end
  end

  assign buttons_o    = buttons_q;
  assign new_press_o  = new_press_q;
  assign present_o    = present_q;
  assign six_button_o = six_button_q;

endmodule

// File: rtl/genesis_pad_scanner.sv
// Genesis pad scanner top: synchronises the pad pins, runs the 8-phase select
// sequence with an idle gap between frames, and strobes one
// pad_decode_debounce per pad. frame_valid is a bare one-cycle pulse with no
// backpressure: the consumer must take buttons/new_press/present/six_button
// in the cycle frame_valid is high (the level outputs then hold until the
// next pulse).
module genesis_pad_scanner
  import genesis_pkg::*;
#(
  parameter int NUM_PADS        = 2,
  parameter int SEL_CYCLES      = 500,
  parameter int IDLE_CYCLES     = 100000,
  parameter int DEBOUNCE_FRAMES = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic [PIN_W*NUM_PADS-1:0] pad_pins,
  output logic                      select,
  output logic [BTN_W*NUM_PADS-1:0] buttons,
  output logic [BTN_W*NUM_PADS-1:0] new_press,
  output logic [NUM_PADS-1:0]       present,
  output logic [NUM_PADS-1:0]       six_button,
  output logic                      frame_valid,
  output phase_e                    dbg_state
);

  localparam int PH_W   = (SEL_CYCLES > 1) ? $clog2(SEL_CYCLES) : 1;
  localparam int IDLE_W = (IDLE_CYCLES > 1) ? $clog2(IDLE_CYCLES) : 1;
  localparam logic [PH_W-1:0]   PH_LAST   = PH_W'(SEL_CYCLES - 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_CYCLES - 1);

  logic [PIN_W*NUM_PADS-1:0] sync1_q, sync2_q;
  phase_e                    state_q;
  logic [PH_W-1:0]           ph_cnt_q;
  logic [IDLE_W-1:0]         idle_cnt_q;
  logic                      select_q;
  logic                      frame_valid_q;
  logic                      phase_last;
  logic                      smp_ph0, smp_ph1, smp_ph5, smp_ph6, commit;

  // Two-flop synchroniser on every pad pin; released pins idle high.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= pad_pins;
      sync2_q <= sync1_q;
    end
  end

  // Scan FSM with its phase/idle counters and registered select/frame_valid.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      ph_cnt_q      <= '0;
      idle_cnt_q    <= '0;
      select_q      <= 1'b1;
      frame_valid_q <= 1'b0;
    end else begin
      frame_valid_q <= 1'b0;
      if (state_q == ST_IDLE) begin
        if ((idle_cnt_q == IDLE_LAST) && enable) begin
          state_q  <= ST_PH0;
          ph_cnt_q <= '0;
          select_q <= phase_select(ST_PH0);
        end else if (idle_cnt_q != IDLE_LAST) begin
          idle_cnt_q <= idle_cnt_q + IDLE_W'(1);
        end
      end else if (phase_last) begin
        ph_cnt_q <= '0;
        state_q  <= next_phase(state_q);
        select_q <= phase_select(next_phase(state_q));
        if (state_q == ST_PH7) begin
          idle_cnt_q    <= '0;
          frame_valid_q <= 1'b1;
        end
      end else begin
        ph_cnt_q <= ph_cnt_q + PH_W'(1);
      end
    end
  end

  // Phase strobes fire on the last cycle of a phase so sync2 has settled.
  always_comb begin
    phase_last = (state_q != ST_IDLE) && (ph_cnt_q == PH_LAST);
    smp_ph0    = phase_last && (state_q == ST_PH0);
    smp_ph1    = phase_last && (state_q == ST_PH1);
    smp_ph5    = phase_last && (state_q == ST_PH5);
    smp_ph6    = phase_last && (state_q == ST_PH6);
    commit     = phase_last && (state_q == ST_PH7);
  end

  for (genvar p = 0; p < NUM_PADS; p++) begin : g_pad
    pad_decode_debounce #(
      .DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)
    ) u_pad (
      .clk_i        (clk),
      .rst_ni       (reset),
      .pins_i       (sync2_q[PIN_W*p +: PIN_W]),
      .smp_ph0_i    (smp_ph0),
      .smp_ph1_i    (smp_ph1),
      .smp_ph5_i    (smp_ph5),
      .smp_ph6_i    (smp_ph6),
      .commit_i     (commit),
      .buttons_o    (buttons[BTN_W*p +: BTN_W]),
      .new_press_o  (new_press[BTN_W*p +: BTN_W]),
      .present_o    (present[p]),
      .six_button_o (six_button[p])
    );
  end

  assign select      = select_q;
  assign frame_valid = frame_valid_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_genesis_pad_scanner.sv
// Bench for genesis_pad_scanner: behavioural pad models on the pins, a
// frame-level reference model, a per-cycle compare process with a frame
// snapshot queue, and directed scenarios with hand-computed expectations.
module tb_genesis_pad_scanner;
  import genesis_pkg::*;

  localparam int NP    = 2;
  localparam int SEL   = 4;
  localparam int IDL   = 16;
  localparam int DEB   = 2;
  localparam int FRAME = IDL + 8 * SEL;

  // ---------------- clock / reset ----------------
  logic clk    = 1'b0;
  logic reset  = 1'b0;
  logic enable = 1'b1;
  always #5 clk = ~clk;

  logic [6*NP-1:0]  pad_pins;
  logic             select;
  logic [12*NP-1:0] buttons;
  logic [12*NP-1:0] new_press;
  logic [NP-1:0]    present;
  logic [NP-1:0]    six_button;
  logic             frame_valid;
  phase_e           dbg_state;

  genesis_pad_scanner #(
    .NUM_PADS(NP), .SEL_CYCLES(SEL), .IDLE_CYCLES(IDL), .DEBOUNCE_FRAMES(DEB)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .pad_pins(pad_pins),
    .select(select), .buttons(buttons), .new_press(new_press),
    .present(present), .six_button(six_button), .frame_valid(frame_valid),
    .dbg_state(dbg_state)
  );

  // ---------------- check bookkeeping ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: bound expired at %0t", name, $time);
  endtask

  // ---------------- pad models ----------------
  // pad_typ: 0 = unplugged, 1 = 3-button, 2 = 6-button. held uses the
  // button bit order up,down,left,right,A,B,C,start,X,Y,Z,mode.
  int          pad_typ [NP];
  logic [11:0] pad_held[NP];
  int          fall_cnt = 0;
  int          hi_run = 0;
  logic        sel_seen = 1'b1;

  // Pin levels a real pad drives for the given select level and count of
  // select falling edges seen since its timeout.
  function automatic logic [5:0] pad_drive(input int typ, input logic [11:0] h,
                                           input logic sel, input int n);
    logic [5:0] lo;  // 1 = pin pulled low, order {start_c,a_b,right,left,down,up_z}
    if (typ == 0) return 6'h3F;
    if (sel) begin
      if (typ == 2 && n == 3) lo = {h[6], h[5], h[11], h[8], h[9], h[10]};
      else                    lo = {h[6], h[5], h[3], h[2], h[1], h[0]};
    end else begin
      if (typ == 2 && n == 3)      lo = {h[7], h[4], 4'b1111};
      else if (typ == 2 && n == 4) lo = {h[7], h[4], 4'b0000};
      else                         lo = {h[7], h[4], 1'b1, 1'b1, h[1], h[0]};
    end
    return ~lo;
  endfunction

  assign pad_pins[5:0]  = pad_drive(pad_typ[0], pad_held[0], select, fall_cnt);
  assign pad_pins[11:6] = pad_drive(pad_typ[1], pad_held[1], select, fall_cnt);

  // Pad-side edge counter with a timeout once select stays high long enough.
  initial begin
    forever begin
      @(negedge clk);
      if (sel_seen && !select) fall_cnt++;
      if (select) hi_run++;
      else        hi_run = 0;
      if (hi_run >= 8) fall_cnt = 0;
      sel_seen = select;
    end
  end

  // ---------------- reference model ----------------
  logic        m_in_frame;
  int          m_idle;
  int          m_pos;
  logic        m_fv;
  logic [23:0] m_np;
  logic [23:0] m_btns;
  logic [1:0]  m_pres;
  logic [1:0]  m_six;
  logic [11:0] m_cand[NP];
  int          m_cnt [NP];
  logic [11:0] m_raw, m_old;
  logic [51:0] exp_q[$];

  function automatic logic m_select();
    if (!m_in_frame) return 1'b1;
    return ((m_pos / SEL) % 2) == 0;
  endfunction

  initial begin
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) begin
        m_in_frame = 1'b0; m_idle = 0; m_pos = 0; m_fv = 1'b0;
        m_np = '0; m_btns = '0; m_pres = '0; m_six = '0;
        for (int p = 0; p < NP; p++) begin m_cand[p] = '0; m_cnt[p] = 0; end
      end else begin
        m_fv = 1'b0;
        m_np = '0;
        if (m_in_frame) begin
          if (m_pos == 8 * SEL - 1) begin
            for (int p = 0; p < NP; p++) begin
              // What the protocol can reveal about this pad's held buttons.
              m_raw = (pad_typ[p] == 0) ? 12'h000 :
                      (pad_typ[p] == 1) ? (pad_held[p] & 12'h0FF) : pad_held[p];
              if (m_raw == m_cand[p]) begin
                if (m_cnt[p] < DEB) m_cnt[p]++;
              end else begin
                m_cand[p] = m_raw;
                m_cnt[p]  = 1;
              end
              m_old = m_btns[12*p +: 12];
              if (m_cnt[p] >= DEB) m_btns[12*p +: 12] = m_cand[p];
              m_np[12*p +: 12] = m_btns[12*p +: 12] & ~m_old;
              m_pres[p] = (pad_typ[p] != 0);
              m_six[p]  = (pad_typ[p] == 2);
            end
            m_fv = 1'b1;
            m_in_frame = 1'b0;
            m_idle = 0;
            exp_q.push_back({m_six, m_pres, m_np, m_btns});
          end else begin
            m_pos++;
          end
        end else if (m_idle >= IDL - 1 && enable) begin
          m_in_frame = 1'b1;
          m_pos = 0;
        end else if (m_idle < IDL - 1) begin
          m_idle++;
        end
      end
    end
  end

  // ---------------- compare process / scoreboard ----------------
  int np4_cnt = 0;
  int np5_cnt = 0;
  logic [51:0] snap;

  initial begin
    forever begin
      @(negedge clk);
      check("select", select, m_select());
      check("frame_valid", frame_valid, m_fv);
      check("buttons", buttons, m_btns);
      check("new_press", new_press, m_np);
      check("present", present, m_pres);
      check("six_button", six_button, m_six);
      if (frame_valid) begin
        if (exp_q.size() == 0) fail_now("frame_snapshot_missing");
        else begin
          snap = exp_q.pop_front();
          check("frame_snapshot", {six_button, present, new_press, buttons}, snap);
        end
      end
      if (new_press[4]) np4_cnt++;
      if (new_press[5]) np5_cnt++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_frame(output int cycles);
    cycles = 0;
    for (int i = 1; i <= 4 * FRAME; i++) begin
      @(posedge clk); #1;
      if (frame_valid) begin cycles = i; return; end
    end
    fail_now("wait_frame");
  endtask

  task automatic wait_state(input phase_e st);
    for (int i = 0; i < 4 * FRAME; i++) begin
      @(posedge clk); #1;
      if (dbg_state == st) return;
    end
    fail_now("wait_state");
  endtask

  // ---------------- directed scenarios ----------------
  int n, t1, t2, snap_np, nfv, nlow;
  logic prev;

  initial begin
    for (int p = 0; p < NP; p++) begin pad_typ[p] = 0; pad_held[p] = '0; end
    reset  = 1'b0;
    enable = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_select", select, 1);
    check("rst_buttons", buttons, 0);
    check("rst_present", present, 0);
    check("rst_frame_valid", frame_valid, 0);
    check("rst_new_press", new_press, 0);
    reset = 1'b1;

    // Empty bus: frame timing and select waveform.
    wait_frame(n);
    check("first_frame_latency", n, FRAME);
    check("empty_present", present, 0);
    wait_frame(n);
    check("frame_period", n, FRAME);
    t1 = -1; t2 = -1; prev = select;
    for (int i = 0; i < 3 * FRAME; i++) begin
      @(posedge clk); #1;
      if (prev && !select) begin
        if (t1 < 0) t1 = i;
        else if (t2 < 0) t2 = i;
      end
      prev = select;
    end
    check("select_period", t2 - t1, 8);
    wait_frame(n);

    // Pad 0: 3-button holding A.
    pad_typ[0] = 1; pad_held[0] = 12'h010;
    snap_np = np4_cnt;
    wait_frame(n);
    check("p0_present", present, 2'b01);
    check("p0_six", six_button, 2'b00);
    check("p0_first_frame_buttons", buttons, 24'h000000);
    wait_frame(n);
    check("p0_a_committed", buttons, 24'h000010);
    check("p0_a_new_press", new_press, 24'h000010);
    wait_frame(n);
    check("p0_a_no_repeat", new_press, 24'h000000);
    check("p0_a_pulse_count", np4_cnt - snap_np, 1);

    // Pad 1: 6-button holding Z and mode.
    pad_typ[1] = 2; pad_held[1] = 12'hC00;
    wait_frame(n);
    check("p1_six_first_frame", six_button, 2'b10);
    check("p1_present", present, 2'b11);
    check("p1_first_frame_buttons", buttons, 24'h000010);
    wait_frame(n);
    check("p1_zm_committed", buttons, 24'hC00010);
    check("p1_zm_new_press", new_press, 24'hC00000);

    // Pad 0 B toggled every frame: never long enough to commit.
    snap_np = np5_cnt;
    for (int k = 0; k < 4; k++) begin
      pad_held[0] = (k % 2 == 0) ? 12'h030 : 12'h010;
      wait_frame(n);
      check("b_toggle_buttons", buttons, 24'hC00010);
      check("b_toggle_new_press", new_press, 24'h000000);
    end
    check("b_toggle_pulse_count", np5_cnt - snap_np, 0);
    pad_held[0] = 12'h010;

    // Reset in PH3: immediate return to reset values, full restart.
    wait_state(ST_PH3);
    check("ph3_select_low", select, 0);
    reset = 1'b0;
    #1;
    check("mid_rst_select", select, 1);
    check("mid_rst_buttons", buttons, 0);
    check("mid_rst_new_press", new_press, 0);
    check("mid_rst_present", present, 0);
    check("mid_rst_six", six_button, 0);
    check("mid_rst_frame_valid", frame_valid, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    wait_frame(n);
    check("post_rst_latency", n, FRAME);
    check("post_rst_present", present, 2'b11);
    check("post_rst_buttons", buttons, 24'h000000);

    // enable dropped in PH2: that frame finishes, then the bus goes quiet.
    wait_state(ST_PH2);
    enable = 1'b0;
    nfv = 0; nlow = 0;
    for (int i = 0; i < 4 * FRAME; i++) begin
      @(posedge clk); #1;
      if (frame_valid) nfv++;
      else if (nfv > 0 && !select) nlow++;
    end
    check("en_drop_frames", nfv, 1);
    check("en_drop_select_quiet", nlow, 0);
    enable = 1'b1;
    wait_frame(n);
    check("en_return_latency", n, 8 * SEL + 1);
    check("en_return_buttons", buttons, 24'hC00010);

    repeat (3) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Global safety net in case a bounded wait is somehow bypassed.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", n_errors + 1, n_checks + 1);
    $fatal(1);
  end

endmodule
